// File: rtl/fifo_async245.sv
// fifo_async245: FT232H async 245-mode FIFO bridge between host pins and RX/TX byte streams on the 12 MHz clock.
//   clk_12mhz/reset           : sole clock, synchronous active-high reset
//   fifo_d                    : bidirectional FTDI data bus, driven only during a write
//   fifo_rxf_n/fifo_txe_n     : FTDI status flags, synchronized over SYNC_STAGES flops
//   fifo_rd_n/fifo_wr_n       : registered active-low strobes
//   fifo_siwu/fifo_oe_n       : tied high; fifo_clkout ignored
//   rx_data/rx_valid/rx_ready : host-to-FPGA byte stream
//   tx_data/tx_valid/tx_ready : FPGA-to-host byte stream
//   Define FIFO_ASYNC245_RX_BUFFER_EN for an RX_DEPTH-entry RX buffer instead of a single register.
module fifo_async245 #(
  parameter int RX_DEPTH    = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_12mhz,
  input  logic       reset,
  inout  wire  [7:0] fifo_d,
  input  logic       fifo_rxf_n,
  input  logic       fifo_txe_n,
  output logic       fifo_rd_n,
  output logic       fifo_wr_n,
  output logic       fifo_siwu,
  output logic       fifo_oe_n,
  input  logic       fifo_clkout,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready
);
  typedef enum logic [2:0] {IDLE, RD_PULSE, WR_SETUP, WR_PULSE, WR_HOLD, RECOVER} state_t;
  state_t state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [SYNC_STAGES-1:0] rxf_sync_q, txe_sync_q;
  logic rxf_s, txe_s;
  logic last_wr_q, last_wr_d;
  logic tx_full_q;
  logic [7:0] tx_byte_q;
  logic rd_n_q, wr_n_q, drive_q;
  logic space, rd_req, wr_req, cap, pop;
  logic unused;
  assign unused = fifo_clkout ^ RX_DEPTH[0];
  assign rxf_s = rxf_sync_q[SYNC_STAGES-1];
  assign txe_s = txe_sync_q[SYNC_STAGES-1];
  assign rd_req = ~rxf_s & space;
  assign wr_req = ~txe_s & tx_full_q;
  // Capture happens on the edge that ends the read pulse, i.e. where rd_n returns high.
  assign cap = (state_q == RD_PULSE) && (cnt_q == 8'd1);
  assign pop = rx_valid && rx_ready;
  assign fifo_rd_n = rd_n_q;
  assign fifo_wr_n = wr_n_q;
  assign fifo_siwu = 1'b1;
  assign fifo_oe_n = 1'b1;
  assign fifo_d = drive_q ? tx_byte_q : 8'hzz;
  assign tx_ready = ~tx_full_q;
  always_ff @(posedge clk_12mhz) begin
    if (reset) begin
      rxf_sync_q <= '1;
      txe_sync_q <= '1;
    end else begin
      rxf_sync_q <= SYNC_STAGES'({rxf_sync_q, fifo_rxf_n});
      txe_sync_q <= SYNC_STAGES'({txe_sync_q, fifo_txe_n});
    end
  end
  always_comb begin
    state_d = state_q;
    last_wr_d = last_wr_q;
    case (state_q)
      IDLE:
        if (rd_req && (!wr_req || last_wr_q)) begin
          state_d = RD_PULSE;
          last_wr_d = 1'b0;
        end else if (wr_req) begin
          state_d = WR_SETUP;
          last_wr_d = 1'b1;
        end
      RD_PULSE: state_d = (cnt_q == 8'd1) ? RECOVER : RD_PULSE;
      WR_SETUP: state_d = WR_PULSE;
      WR_PULSE: state_d = (cnt_q == 8'd1) ? WR_HOLD : WR_PULSE;
      WR_HOLD:  state_d = RECOVER;
      // Lasts SYNC_STAGES+1 cycles so the flags seen in IDLE reflect the post-strobe FTDI state.
      RECOVER:  state_d = (cnt_q == 8'(SYNC_STAGES)) ? IDLE : RECOVER;
      default:  state_d = IDLE;
    endcase
    cnt_d = (state_d == state_q) ? cnt_q + 8'd1 : 8'd0;
  end
  // Strobes and bus enable are registered from the next state so they never glitch.
  always_ff @(posedge clk_12mhz) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= 8'd0;
      last_wr_q <= 1'b1;
      rd_n_q <= 1'b1;
      wr_n_q <= 1'b1;
      drive_q <= 1'b0;
      tx_full_q <= 1'b0;
      tx_byte_q <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      last_wr_q <= last_wr_d;
      rd_n_q <= state_d != RD_PULSE;
      wr_n_q <= state_d != WR_PULSE;
      drive_q <= state_d inside {WR_SETUP, WR_PULSE, WR_HOLD};
      if (tx_valid && tx_ready) begin
        tx_full_q <= 1'b1;
        tx_byte_q <= tx_data;
      end else if (state_q == WR_HOLD) begin
        tx_full_q <= 1'b0;
      end
    end
  end
`ifdef FIFO_ASYNC245_RX_BUFFER_EN
  localparam int PW = $clog2(RX_DEPTH);
  logic [7:0] mem_q [RX_DEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [PW:0] count_q;
  assign space = ({1'b0, count_q} + (PW+2)'(state_q == RD_PULSE)) < (PW+2)'(RX_DEPTH);
  assign rx_valid = count_q != '0;
  assign rx_data = mem_q[rptr_q];
  always_ff @(posedge clk_12mhz) begin
    if (reset) begin
      for (int i = 0; i < RX_DEPTH; i++) mem_q[i] <= 8'h00;
      wptr_q <= '0;
      rptr_q <= '0;
      count_q <= '0;
    end else begin
      if (cap) begin
        mem_q[wptr_q] <= fifo_d;
        wptr_q <= wptr_q + PW'(1);
      end
      if (pop) rptr_q <= rptr_q + PW'(1);
      count_q <= count_q + (PW+1)'(cap) - (PW+1)'(pop);
    end
  end
`else
  logic [7:0] rx_data_q;
  logic rx_valid_q;
  assign space = ~rx_valid_q;
  assign rx_valid = rx_valid_q;
  assign rx_data = rx_data_q;
  always_ff @(posedge clk_12mhz) begin
    if (reset) begin
      rx_data_q <= 8'h00;
      rx_valid_q <= 1'b0;
    end else if (cap) begin
      rx_data_q <= fifo_d;
      rx_valid_q <= 1'b1;
    end else if (pop) begin
      rx_valid_q <= 1'b0;
    end
  end
`endif
endmodule
